// File: rtl/out_port_ctrl.sv
// Output port controller: small write buffer feeding a 4-phase strobe/ack handshake.
// Define OUTPORT_FIFO_EN for a 4-word buffer; otherwise a single holding register is used.
module out_port_ctrl (
  input  logic        clk,
  input  logic        clr,
  input  logic        OutportIn,
  input  logic [31:0] BusMuxOut,
  output logic [31:0] Output,
  output logic        OutStrobe,
  input  logic        OutAck,
  output logic        OutFull,
  output logic        OutEmpty,
  output logic [2:0]  OutCount,
  output logic        OutOverflow
);

`ifdef OUTPORT_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (DEPTH > 1) ? 3 : 1;

  typedef enum logic [1:0] {
    IDLE,
    STROBE,
    RELEASE
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     mem_q [DEPTH];
  logic [31:0]     head;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     out_q, out_d;
  logic            strobe_q, strobe_d;
  logic            ovf_q, ovf_d;
  logic            full, empty, push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  // Fullness comes from start-of-cycle state, so a pop on the same edge never rescues a write.
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign push  = OutportIn && !full;

  if (DEPTH == 1) begin : g_single
    assign head = mem_q[0];
  end else begin : g_multi
    assign head = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push && (wr_ptr_q == PW'(i))) begin
        mem_q[i] <= BusMuxOut;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        // A lingering ack from the previous transfer must drop before the next pop.
        if (!empty && !OutAck) begin
          pop     = 1'b1;
          state_d = STROBE;
        end
      end
      STROBE: begin
        if (OutAck) begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!OutAck) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    out_d    = pop ? head : out_q;
    strobe_d = (state_d == STROBE);
    ovf_d    = ovf_q | (OutportIn & full);
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      out_q    <= '0;
      strobe_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      out_q    <= out_d;
      strobe_q <= strobe_d;
      ovf_q    <= ovf_d;
    end
  end

  assign Output      = out_q;
  assign OutStrobe   = strobe_q;
  assign OutFull     = full;
  assign OutEmpty    = empty;
  assign OutCount    = 3'(count_q);
  assign OutOverflow = ovf_q;

endmodule

// File: tb/tb_out_port_ctrl.sv
// Scoreboard bench for out_port_ctrl: accepted writes are queued, presented words are checked in order.
module tb_out_port_ctrl;

`ifdef OUTPORT_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        OutportIn = 1'b0;
  logic [31:0] BusMuxOut = '0;
  logic [31:0] Output;
  logic        OutStrobe;
  logic        OutAck = 1'b0;
  logic        OutFull;
  logic        OutEmpty;
  logic [2:0]  OutCount;
  logic        OutOverflow;

  int          n_checks = 0;
  int          n_fail = 0;
  int          n_xfer = 0;
  logic [31:0] exp_q [$];
  logic        exp_ovf = 1'b0;
  logic        prev_strobe = 1'b0;

  out_port_ctrl dut (
    .clk        (clk),
    .clr        (clr),
    .OutportIn  (OutportIn),
    .BusMuxOut  (BusMuxOut),
    .Output     (Output),
    .OutStrobe  (OutStrobe),
    .OutAck     (OutAck),
    .OutFull    (OutFull),
    .OutEmpty   (OutEmpty),
    .OutCount   (OutCount),
    .OutOverflow(OutOverflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge; a rising OutStrobe means a word was popped and must match the queue head.
  task automatic tick();
    logic [31:0] w;
    @(posedge clk);
    #1;
    if (OutStrobe === 1'b1 && !prev_strobe) begin
      check("pop_has_data", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        n_xfer++;
        $display("xfer %0d: Output=%h expected=%h", n_xfer, Output, w);
        check("pop_data", Output, w);
      end
    end
    prev_strobe = OutStrobe;
  endtask

  task automatic wr(input logic [31:0] d);
    bit acc;
    acc = (exp_q.size() < DEPTH);
    OutportIn = 1'b1;
    BusMuxOut = d;
    tick();
    OutportIn = 1'b0;
    BusMuxOut = '0;
    if (acc) exp_q.push_back(d);
    else exp_ovf = 1'b1;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_count"}, 32'(OutCount), 32'(exp_q.size()));
    check({tag, "_empty"}, 32'(OutEmpty), 32'(exp_q.size() == 0));
    check({tag, "_full"},  32'(OutFull),  32'(exp_q.size() == DEPTH));
    check({tag, "_ovf"},   32'(OutOverflow), 32'(exp_ovf));
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    exp_q.delete();
    exp_ovf = 1'b0;
  endtask

  // Responsive acknowledge until every queued word has been presented and released.
  task automatic drain();
    int budget = 200;
    while ((exp_q.size() != 0 || OutStrobe) && budget > 0) begin
      OutAck = OutStrobe;
      tick();
      budget--;
    end
    OutAck = 1'b0;
    tick();
    tick();
    check("drain_in_budget", 32'(budget > 0), 32'd1);
  endtask

  initial begin
    // Reset state
    tick();
    do_clr();
    check("rst_output", Output, 32'h0);
    check("rst_strobe", 32'(OutStrobe), 32'd0);
    check_status("rst");

    // Single word, latency and 4-phase handshake
    wr(32'h0000_0002);
    check("lat_n_strobe", 32'(OutStrobe), 32'd0);
    check_status("lat_n");
    tick();
    check("lat_n1_strobe", 32'(OutStrobe), 32'd1);
    check("lat_n1_output", Output, 32'h2);
    tick();
    tick();
    check("strobe_hold", 32'(OutStrobe), 32'd1);
    OutAck = 1'b1;
    tick();
    check("release_strobe", 32'(OutStrobe), 32'd0);
    tick();
    check("release_hold", 32'(OutStrobe), 32'd0);
    OutAck = 1'b0;
    tick();
    check("output_held", Output, 32'h2);
    check_status("single_done");

    // Stale acknowledge in IDLE blocks the pop
    OutAck = 1'b1;
    wr(32'h0000_0077);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stale_strobe", 32'(OutStrobe), 32'd0);
      check_status("stale");
    end
    OutAck = 1'b0;
    tick();
    check("stale_pop_strobe", 32'(OutStrobe), 32'd1);
    drain();

    // Fill past capacity, then drain in order
    do_clr();
`ifdef OUTPORT_FIFO_EN
    for (int i = 0; i < 5; i++) wr(32'hA0 + 32'(i));
    check("burst_output", Output, 32'hA0);
    check_status("burst");
    wr(32'hA5);
    check_status("burst_ovf");
`else
    wr(32'h11);
    tick();
    wr(32'h22);
    check("hold_output", Output, 32'h11);
    check("hold_strobe", 32'(OutStrobe), 32'd1);
    check_status("hold");
    wr(32'h33);
    check_status("hold_ovf");
`endif
    drain();
    check_status("drained");

    // Write while full on the same edge as a pop is dropped
    do_clr();
    OutAck = 1'b1;
    for (int i = 0; i < DEPTH; i++) wr(32'hC0 + 32'(i));
    check_status("full_idle");
    OutAck = 1'b0;
    wr(32'hCF);
    check("samedge_strobe", 32'(OutStrobe), 32'd1);
    check_status("samedge");

    // Reset in the middle of a handshake with data buffered
    if (exp_q.size() == 0) wr(32'h99);
    check("pre_clr_strobe", 32'(OutStrobe), 32'd1);
    do_clr();
    check("midclr_strobe", 32'(OutStrobe), 32'd0);
    check("midclr_output", Output, 32'h0);
    check_status("midclr");
    for (int i = 0; i < 3; i++) tick();
    check("postclr_strobe", 32'(OutStrobe), 32'd0);
    check_status("postclr");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
